// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one external ALU.
// Owns the ALU input registers and samples BusW/Zero after a fixed settle time.
module alu_share_arbiter #(
    parameter int N       = 64,
    parameter int ALU_LAT = 2
) (
    input  logic         CLK,
    input  logic         Reset_L,
    input  logic         req0_valid,
    input  logic [3:0]   req0_ctrl,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [3:0]   req1_ctrl,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         resp0_valid,
    output logic         resp1_valid,
    output logic [N-1:0] resp_data,
    output logic         resp_zero,
    output logic         resp_err,
    output logic [3:0]   alu_ctrl,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_w,
    input  logic         alu_zero
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           grant_q, grant_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     alu_ctrl_q, alu_ctrl_d;
    logic [N-1:0]   alu_a_q, alu_a_d;
    logic [N-1:0]   alu_b_q, alu_b_d;
    logic [N-1:0]   resp_data_q, resp_data_d;
    logic           resp_zero_q, resp_zero_d;
    logic           resp_err_q, resp_err_d;
    logic           resp0_valid_q, resp0_valid_d;
    logic           resp1_valid_q, resp1_valid_d;

    logic           gnt_s;
    logic           accept_s;
    logic           legal_s;
    logic [3:0]     sel_ctrl_s;
    logic [N-1:0]   sel_a_s;
    logic [N-1:0]   sel_b_s;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: op_is_legal = 1'b1;
            default:                                     op_is_legal = 1'b0;
        endcase
    endfunction

    // Grantee pick: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        gnt_s = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_s = ~last_grant_q;
        end else if (req1_valid) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
        sel_ctrl_s = gnt_s ? req1_ctrl : req0_ctrl;
        sel_a_s    = gnt_s ? req1_a    : req0_a;
        sel_b_s    = gnt_s ? req1_b    : req0_b;
        accept_s   = (state_q == ST_IDLE) && (req0_valid || req1_valid);
        legal_s    = op_is_legal(sel_ctrl_s);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = legal_s ? ST_WAIT : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath next values; response pulses default low so RESP lasts one cycle
    always_comb begin
        req0_ready    = accept_s && !gnt_s;
        req1_ready    = accept_s &&  gnt_s;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        alu_ctrl_d    = alu_ctrl_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        resp_data_d   = resp_data_q;
        resp_zero_d   = resp_zero_q;
        resp_err_d    = 1'b0;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    last_grant_d = gnt_s;
                    grant_d      = gnt_s;
                    if (legal_s) begin
                        alu_ctrl_d = sel_ctrl_s;
                        alu_a_d    = sel_a_s;
                        alu_b_d    = sel_b_s;
                        cnt_d      = CNT_INIT;
                    end else begin
                        // Rejected opcode never reaches the ALU; answer straight away
                        resp_data_d   = '0;
                        resp_zero_d   = 1'b0;
                        resp_err_d    = 1'b1;
                        resp0_valid_d = !gnt_s;
                        resp1_valid_d =  gnt_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    resp_data_d   = alu_w;
                    resp_zero_d   = alu_zero;
                    resp0_valid_d = !grant_q;
                    resp1_valid_d =  grant_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath and response registers
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            cnt_q         <= 4'd0;
            alu_ctrl_q    <= 4'b0000;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            resp_data_q   <= '0;
            resp_zero_q   <= 1'b0;
            resp_err_q    <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            resp_data_q   <= resp_data_d;
            resp_zero_q   <= resp_zero_d;
            resp_err_q    <= resp_err_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
        end
    end

    assign alu_ctrl    = alu_ctrl_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign resp_data   = resp_data_q;
    assign resp_zero   = resp_zero_q;
    assign resp_err    = resp_err_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter: a slow ALU model plus a transaction-level
// reference (busy window, round-robin pointer, one outstanding response).
module tb_alu_share_arbiter;

    localparam int N       = 64;
    localparam int ALU_LAT = 2;
    localparam int PIDX    = (ALU_LAT > 1) ? ALU_LAT - 2 : 0;

    logic         CLK = 1'b0;
    logic         Reset_L;
    logic         req0_valid, req1_valid;
    logic [3:0]   req0_ctrl, req1_ctrl;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp1_valid;
    logic [N-1:0] resp_data;
    logic         resp_zero, resp_err;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_a, alu_b;
    logic [N-1:0] alu_w;
    logic         alu_zero;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.N(N), .ALU_LAT(ALU_LAT)) dut (
        .CLK(CLK), .Reset_L(Reset_L),
        .req0_valid(req0_valid), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_w(alu_w), .alu_zero(alu_zero)
    );

    always #5 CLK = ~CLK;

    function automatic logic [N:0] alu_f(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] w;
        case (c)
            4'b0000: w = a & b;
            4'b0001: w = a | b;
            4'b0010: w = a + b;
            4'b0110: w = a - b;
            4'b0111: w = b;
            default: w = '0;
        endcase
        return {(w == '0), w};
    endfunction

    // ALU model: result only appears ALU_LAT cycles after its inputs change
    logic [N:0] alu_pipe [0:15];
    initial for (int i = 0; i < 16; i++) alu_pipe[i] = '0;
    always @(posedge CLK) begin
        alu_pipe[0] <= alu_f(alu_ctrl, alu_a, alu_b);
        for (int i = 1; i < 16; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign {alu_zero, alu_w} = (ALU_LAT == 1) ? alu_f(alu_ctrl, alu_a, alu_b) : alu_pipe[PIDX];

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    int           cyc = 0;
    int           free_at = 0;
    bit           m_last = 1'b1;
    bit           pend = 1'b0;
    int           pend_at = 0;
    bit           pend_who, pend_err, pend_zero;
    logic [N-1:0] pend_data;
    logic [N-1:0] exp_data = '0, exp_a = '0, exp_b = '0;
    logic         exp_zero = 1'b0;
    logic [3:0]   exp_ctrl = 4'b0000;
    int           grants0 = 0, grants1 = 0;

    task automatic step(input bit rst,
                        input bit v0, input logic [3:0] c0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                        input bit v1, input logic [3:0] c1, input logic [N-1:0] a1, input logic [N-1:0] b1);
        bit rv, idle, g, er0, er1, who, lg;
        logic [3:0] c;
        logic [N-1:0] a, b;
        logic [N:0] r;
        @(negedge CLK);
        rv = pend && (pend_at == cyc);
        if (rv) begin
            exp_data = pend_data;
            exp_zero = pend_zero;
        end
        chk("resp0_valid", {63'd0, resp0_valid}, {63'd0, rv && !pend_who});
        chk("resp1_valid", {63'd0, resp1_valid}, {63'd0, rv && pend_who});
        chk("resp_err", {63'd0, resp_err}, {63'd0, rv && pend_err});
        chk("resp_data", resp_data, exp_data);
        chk("resp_zero", {63'd0, resp_zero}, {63'd0, exp_zero});
        chk("alu_ctrl", {60'd0, alu_ctrl}, {60'd0, exp_ctrl});
        chk("alu_a", alu_a, exp_a);
        chk("alu_b", alu_b, exp_b);
        if (rv) pend = 1'b0;
        Reset_L    = !rst;
        req0_valid = v0 && !rst; req0_ctrl = c0; req0_a = a0; req0_b = b0;
        req1_valid = v1 && !rst; req1_ctrl = c1; req1_a = a1; req1_b = b1;
        #1;
        idle = (cyc >= free_at);
        g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
        er0  = idle && req0_valid && !g;
        er1  = idle && req1_valid && g;
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, er0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, er1});
        @(posedge CLK);
        if (rst) begin
            free_at = cyc + 1; m_last = 1'b1; pend = 1'b0;
            exp_ctrl = 4'b0000; exp_a = '0; exp_b = '0; exp_data = '0; exp_zero = 1'b0;
        end else if (er0 || er1) begin
            who = er1; m_last = who;
            if (who) grants1++; else grants0++;
            c = who ? c1 : c0; a = who ? a1 : a0; b = who ? b1 : b0;
            lg = c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
            pend = 1'b1; pend_who = who; pend_err = !lg;
            if (lg) begin
                r = alu_f(c, a, b);
                pend_data = r[N-1:0]; pend_zero = r[N];
                pend_at = cyc + ALU_LAT + 1; free_at = cyc + ALU_LAT + 2;
                exp_ctrl = c; exp_a = a; exp_b = b;
            end else begin
                pend_data = '0; pend_zero = 1'b0;
                pend_at = cyc + 1; free_at = cyc + 2;
            end
        end
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0);
    endtask

    logic [3:0] ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};

    function automatic logic [3:0] rnd_op();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
        return ops[$urandom_range(0, 4)];
    endfunction

    function automatic logic [N-1:0] rnd_val();
        if ($urandom_range(0, 3) == 0) return N'($urandom_range(0, 3));
        return {$urandom, $urandom};
    endfunction

    initial begin
        Reset_L = 1'b0;
        req0_valid = 1'b0; req0_ctrl = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_ctrl = 4'd0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge CLK);

        // T1/T2: reset values, then a lone ADD
        step(1'b0, 1'b1, 4'b0010, 64'd5, 64'd7, 1'b0, 4'd0, '0, '0);
        idle_steps(ALU_LAT + 2);
        chk("t2_data", resp_data, 64'd12);

        // T3: both requesting continuously from a fresh reset
        step(1'b1, 1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0);
        grants0 = 0; grants1 = 0;
        for (int i = 0; i < 4 * (ALU_LAT + 2); i++)
            step(1'b0, 1'b1, 4'b0110, 64'd9, 64'd9, 1'b1, 4'b0001, 64'hF0, 64'h0F);
        chk("t3_grants0", 64'(grants0), 64'd2);
        chk("t3_grants1", 64'(grants1), 64'd2);
        idle_steps(ALU_LAT + 2);

        // T4: illegal opcode; T5: SUB wrap
        step(1'b0, 1'b0, 4'd0, '0, '0, 1'b1, 4'b1010, 64'd3, 64'd4);
        idle_steps(2);
        step(1'b0, 1'b1, 4'b0110, 64'd0, 64'd1, 1'b0, 4'd0, '0, '0);
        idle_steps(ALU_LAT + 2);
        chk("t5_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);

        // T6: reset while waiting on the ALU, then a tie
        step(1'b0, 1'b0, 4'd0, '0, '0, 1'b1, 4'b0010, 64'd1, 64'd1);
        step(1'b1, 1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0);
        grants0 = 0;
        step(1'b0, 1'b1, 4'b0000, 64'hFF, 64'h0F, 1'b1, 4'b0111, 64'd0, 64'd42);
        chk("t6_tie_req0", 64'(grants0), 64'd1);
        idle_steps(ALU_LAT + 2);

        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0, rnd_op(), rnd_val(), rnd_val(),
                 $urandom_range(0, 2) != 0, rnd_op(), rnd_val(), rnd_val());
        idle_steps(ALU_LAT + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
